// File: rtl/shape_classifier.sv
// -----------------------------------------------------------------------------
// shape_classifier
//
// Recovers the canonical block type and the clockwise rotation count of a
// 3x3 piece bitmap. The shape is latched once. After that, one orientation
// is compared against the canonical table on each clock. If no match is
// found, the working copy is rotated clockwise and the next orientation is
// tried.
//
// Ports:
//   i_clk         system clock, all logic on the rising edge
//   i_rst         synchronous, active-high reset
//   i_start       request pulse, accepted only when idle or in the done cycle
//   i_shape_in    bitmap, bit 3r+c = row r / col c, bit 0 = top-left (MSB)
//   o_busy        high while a classification is in progress
//   o_done        one-cycle pulse when the results update
//   o_valid       result is a known type (including empty)
//   o_block_type  0..5 canonical type, 6 = empty, 7 = no match
//   o_rotation    clockwise rotations applied to reach canonical form
// -----------------------------------------------------------------------------
module shape_classifier #(
  parameter int MAX_ROT = 3
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [0:8] i_shape_in,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_valid,
  output logic [2:0] o_block_type,
  output logic [1:0] o_rotation
);

  localparam logic [1:0] LP_MAX_ROT = 2'(MAX_ROT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [0:8] r_work;
  logic [0:8] w_work_nxt;
  logic [1:0] r_cnt;
  logic [1:0] w_cnt_nxt;
  logic       r_busy;
  logic       r_done;
  logic       r_valid;
  logic [2:0] r_type;
  logic [1:0] r_rot;
  logic       w_busy_nxt;
  logic       w_done_nxt;
  logic       w_valid_nxt;
  logic [2:0] w_type_nxt;
  logic [1:0] w_rot_nxt;
  logic [2:0] w_match;

  // Canonical lookup. The table entries are distinct, so at most one entry
  // can hit. Code 7 means that none of them match.
  function automatic logic [2:0] match_canon(input logic [0:8] s);
    logic [2:0] t;
    case (s)
      9'h198:  t = 3'd0;
      9'h027:  t = 3'd1;
      9'h092:  t = 3'd2;
      9'h036:  t = 3'd3;
      9'h017:  t = 3'd4;
      9'h097:  t = 3'd5;
      default: t = 3'd7;
    endcase
    return t;
  endfunction

  // Clockwise rotation: new[r][c] = old[2-c][r].
  function automatic logic [0:8] rotate_cw(input logic [0:8] s);
    logic [0:8] n;
    n = 9'h000;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        n[3*r+c] = s[3*(2-c)+r];
      end
    end
    return n;
  endfunction

  assign w_match = match_canon(r_work);

  // State, datapath and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_work  <= 9'h000;
      r_cnt   <= 2'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_valid <= 1'b0;
      r_type  <= 3'd0;
      r_rot   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_work  <= w_work_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_valid <= w_valid_nxt;
      r_type  <= w_type_nxt;
      r_rot   <= w_rot_nxt;
    end
  end

  // Next state, working register, counter and result values.
  always_comb begin
    w_state_nxt = r_state;
    w_work_nxt  = r_work;
    w_cnt_nxt   = r_cnt;
    w_valid_nxt = r_valid;
    w_type_nxt  = r_type;
    w_rot_nxt   = r_rot;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          // A new request clears the old result, so a stale result is never
          // shown as valid while the new one is being computed.
          w_state_nxt = S_CHECK;
          w_work_nxt  = i_shape_in;
          w_cnt_nxt   = 2'd0;
          w_valid_nxt = 1'b0;
          w_type_nxt  = 3'd0;
          w_rot_nxt   = 2'd0;
        end else if (r_state == S_DONE) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_CHECK: begin
        if ((r_work == 9'h000) && (r_cnt == 2'd0)) begin
          w_state_nxt = S_DONE;
          w_valid_nxt = 1'b1;
          w_type_nxt  = 3'd6;
          w_rot_nxt   = 2'd0;
        end else if (w_match != 3'd7) begin
          w_state_nxt = S_DONE;
          w_valid_nxt = 1'b1;
          w_type_nxt  = w_match;
          w_rot_nxt   = r_cnt;
        end else if (r_cnt == LP_MAX_ROT) begin
          w_state_nxt = S_DONE;
          w_valid_nxt = 1'b0;
          w_type_nxt  = 3'd7;
          w_rot_nxt   = LP_MAX_ROT;
        end else begin
          w_work_nxt = rotate_cw(r_work);
          w_cnt_nxt  = r_cnt + 2'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Status flags for the next cycle. They are derived from the next state so
  // that they can be registered and line up with it.
  always_comb begin
    w_busy_nxt = 1'b0;
    w_done_nxt = 1'b0;
    if (w_state_nxt == S_CHECK) begin
      w_busy_nxt = 1'b1;
    end else if (w_state_nxt == S_DONE) begin
      w_done_nxt = 1'b1;
    end else begin
      w_busy_nxt = 1'b0;
      w_done_nxt = 1'b0;
    end
  end

  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_valid      = r_valid;
  assign o_block_type = r_type;
  assign o_rotation   = r_rot;

endmodule

// File: doc/shape_classifier.md
Name: shape_classifier

Overview:
- Inverse of the block-type-to-shape lookup. Takes a 9-bit 3x3 piece bitmap in any of its four orientations and recovers the canonical block type plus the number of clockwise rotations applied.
- Works sequentially: latches the shape, then compares and rotates one orientation per clock.
- Used by the game controller to re-identify a piece after rotation, and for board/piece consistency checks.

Parameters:
- MAX_ROT, 3, last rotation index tried before reporting no-match (rotations 0..MAX_ROT).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request pulse; sampled only when ready (state IDLE or DONE)
- shape_in  input  [0:8]  bitmap; bit 3r+c = row r, col c; bit 0 = top-left (MSB)
- busy  output  1  high while a classification is in progress
- done  output  1  one-cycle pulse when results update
- valid  output  1  result is a known type (including empty)
- block_type  output  [2:0]  decoded type 0..5, 6 = empty, 7 = no match
- rotation  output  [1:0]  clockwise rotations applied to shape_in to reach canonical form

Behaviour:
- Canonical table (rows top to bottom):
  - 0 = 110/011/000 (9'h198)
  - 1 = 000/100/111 (9'h027)
  - 2 = 010/010/010 (9'h092)
  - 3 = 000/110/110 (9'h036)
  - 4 = 000/010/111 (9'h017)
  - 5 = 010/010/111 (9'h097)
- Clockwise rotation: new[r][c] = old[2-c][r]. Matching is exact and positional; there is no translation normalisation.
- Reset (rst=1 at an edge): state to IDLE; busy=0, done=0, valid=0, block_type=0, rotation=0; working register and rotation counter cleared. Applies mid-operation too; the in-flight result is discarded.
- States: IDLE, CHECK, DONE.
  - IDLE: on start=1, latch shape_in into the working register, clear the counter, go to CHECK, busy=1.
  - CHECK, one orientation per cycle, first matching condition wins:
    - Working register == 0 at counter 0: result type 6, valid=1, rotation 0, go to DONE.
    - Working register equals any canonical: type = its index, rotation = counter, valid=1, go to DONE. Table entries are distinct, so at most one match.
    - Counter == MAX_ROT: type 7, valid=0, rotation = MAX_ROT, go to DONE.
    - Otherwise: rotate the working register, increment the counter, stay in CHECK.
  - DONE: done=1 and busy=0 for exactly this cycle. Results (valid, block_type, rotation) update on entry and hold until the next accepted start or reset. If start=1 here, latch the new shape and go directly to CHECK. Otherwise go to IDLE.
- Latency: start sampled at edge 0; done high in cycle 2 + rotation on a match. No-match: done in cycle 2 + MAX_ROT (cycle 5 at default).
- start while busy=1 is ignored; shape_in is not re-sampled mid-operation.
- Outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset, then shape_in=9'h198, start pulse -> done in cycle 2, block_type=0, rotation=0, valid=1; busy high cycle 1 only.
- shape_in=9'h038 (000/111/000) -> done cycle 3, block_type=2, rotation=1, valid=1.
- shape_in=9'h1D0 (111/010/000) -> done cycle 4, block_type=4, rotation=2, valid=1.
- shape_in=9'h1FF -> done cycle 5, block_type=7, valid=0, rotation=3. Then shape_in=9'h000 -> done 2 cycles after start, block_type=6, valid=1, rotation=0.
- Start 9'h1D0, pulse start again with 9'h198 while busy -> second start ignored, result type 4. Then assert start with 9'h097 during the done cycle -> accepted back-to-back, type 5, rotation 0, done 2 cycles later.
- Start 9'h1FF, assert rst in cycle 2 -> busy=0, done never pulses, all outputs 0. Next start with 9'h027 -> type 1, rotation 0.
